// File: rtl/data_lane_destriper.sv
// Lane destriper: captures one lane-aligned beat and serializes its enabled lanes, lane 0 first.
// Optional illegal lane-enable detection is built when DESTRIPER_LANE_CHECK_EN is defined.
module data_lane_destriper #(
    parameter int NUM_LANES  = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] striped_data_i [NUM_LANES],
    input  logic                  striped_data_valid_i,
    output logic                  striped_data_ready_o,
    input  logic                  lanes_enabled_i [NUM_LANES],
    output logic [DATA_WIDTH-1:0] destriped_data_o,
    output logic                  destriped_data_valid_o,
    input  logic                  destriped_data_ready_i,
    output logic                  lane_cfg_err_o,
    output logic                  state_dbg_o
);

    localparam int CW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int KW = $clog2(NUM_LANES + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        UNPACK = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         cntr_max_q, cntr_max_d;
    logic [DATA_WIDTH-1:0] lane_buf_q [NUM_LANES];
    logic [KW-1:0]         lane_cnt;
    logic                  last_accept;
    logic                  capture;
    logic                  ready;

    // Both ports use valid/ready: a transfer happens on the rising edge where
    // valid and ready are both 1; a producer holds data stable while valid=1
    // and ready=0. Input ready is combinational so a new beat can be taken on
    // the same edge the last symbol of the current beat leaves (no bubble).
    always_comb begin
        lane_cnt = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_cnt = lane_cnt + KW'(lanes_enabled_i[i]);
        end
        cntr_max_d = CW'(lane_cnt - KW'(1));
    end

    always_comb begin
        last_accept = (state_q == UNPACK) && destriped_data_ready_i && (cnt_q == cntr_max_q);
        ready       = rst_ni && (lane_cnt != '0) && ((state_q == IDLE) || last_accept);
        capture     = striped_data_valid_i && ready;
        state_d     = state_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d = UNPACK;
                    cnt_d   = '0;
                end
            end
            UNPACK: begin
                if (destriped_data_ready_i) begin
                    if (cnt_q == cntr_max_q) begin
                        state_d = capture ? UNPACK : IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cntr_max_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                cntr_max_q <= cntr_max_d;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_buf_q[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_buf_q[i] <= striped_data_i[i];
            end
        end
    end

    assign striped_data_ready_o   = ready;
    assign destriped_data_valid_o = (state_q == UNPACK);
    assign destriped_data_o       = (state_q == UNPACK) ? lane_buf_q[cnt_q] : '0;
    assign state_dbg_o            = (state_q == UNPACK);

`ifdef DESTRIPER_LANE_CHECK_EN
    logic therm_bad;
    logic err_q;

    // A lane enabled above a disabled one breaks the thermometer code.
    always_comb begin
        therm_bad = 1'b0;
        for (int i = 0; i < NUM_LANES - 1; i++) begin
            if (lanes_enabled_i[i+1] && !lanes_enabled_i[i]) begin
                therm_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (striped_data_valid_i && therm_bad) begin
            err_q <= 1'b1;
        end
    end

    assign lane_cfg_err_o = err_q;
`else
    assign lane_cfg_err_o = 1'b0;
`endif

endmodule

// File: doc/data_lane_destriper.md
DATA_LANE_DESTRIPER -- requirements
Module: data_lane_destriper

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, number of physical lanes (>=2).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, symbol width per lane.
REQ-003 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port striped_data_i  input  DATA_WIDTH x NUM_LANES (unpacked array)  one symbol per lane, lane-aligned beat.
REQ-006 SHALL have port striped_data_valid_i  input  1  beat on striped_data_i valid.
REQ-007 SHALL have port striped_data_ready_o  output  1  block accepts beat this cycle.
REQ-008 SHALL have port lanes_enabled_i  input  1 x NUM_LANES (unpacked array)  thermometer lane enable, lane 0 first.
REQ-009 SHALL have port destriped_data_o  output  DATA_WIDTH  serialized symbol.
REQ-010 SHALL have port destriped_data_valid_o  output  1  destriped_data_o valid.
REQ-011 SHALL have port destriped_data_ready_i  input  1  downstream accepts symbol.
REQ-012 SHALL have port lane_cfg_err_o  output  1  sticky illegal lane-enable flag (see Configuration).

Function
REQ-013 SHALL implement FSM states IDLE and UNPACK.
REQ-014 SHALL compute lane count K as the number of set bits in lanes_enabled_i, and last-index cntr_max = K-1 at width $clog2(NUM_LANES).
REQ-015 SHALL accept a beat when striped_data_valid_i and striped_data_ready_o are both 1 on the same edge ("capture").
REQ-016 SHALL drive striped_data_ready_o = 1 when in IDLE with K>0, or when in UNPACK with the last symbol being accepted this cycle and K>0 (combinational, zero-bubble).
REQ-017 SHALL drive striped_data_ready_o = 0 whenever K==0, so no capture occurs with no lanes enabled.
REQ-018 On capture, SHALL register all NUM_LANES symbols into a lane buffer, latch cntr_max, clear symbol counter cnt to 0, and enter UNPACK next cycle.
REQ-019 In UNPACK, SHALL drive destriped_data_valid_o = 1 and destriped_data_o = buffer[cnt].
REQ-020 SHALL hold destriped_data_o and destriped_data_valid_o stable while destriped_data_valid_o=1 and destriped_data_ready_i=0.
REQ-021 On destriped_data_valid_o & destriped_data_ready_i with cnt != latched cntr_max, SHALL increment cnt by 1.
REQ-022 On acceptance with cnt == latched cntr_max, SHALL return to IDLE, or remain in UNPACK with cnt=0 and new buffer contents if a capture occurs on the same edge.
REQ-023 SHALL ignore changes to lanes_enabled_i during UNPACK; the latched cntr_max governs the current beat.
REQ-024 SHALL produce first output symbol 1 cycle after capture; sustained throughput SHALL be K symbols per K cycles with continuous valid/ready.
REQ-025 In IDLE, SHALL drive destriped_data_valid_o = 0 and destriped_data_o = 0.

Reset
REQ-026 On rst_ni=0, SHALL asynchronously force state=IDLE, cnt=0, cntr_max=0, lane buffer=0, lane_cfg_err_o=0.
REQ-027 During reset, SHALL output striped_data_ready_o=0, destriped_data_valid_o=0, destriped_data_o=0.
REQ-028 Reset asserted mid-UNPACK SHALL discard the remaining buffered symbols; none are emitted after deassertion.
REQ-029 SHALL deassert reset synchronously to clk_i externally; the block requires no internal reset synchronizer.

Configuration
REQ-030 With DESTRIPER_LANE_CHECK_EN defined, SHALL set lane_cfg_err_o to 1 on any edge where striped_data_valid_i=1 and lanes_enabled_i is not thermometer-coded (a 1 above a 0); the flag is sticky until reset.
REQ-031 With DESTRIPER_LANE_CHECK_EN defined, SHALL still capture the beat and use the popcount of lanes_enabled_i as K.
REQ-032 Without DESTRIPER_LANE_CHECK_EN, SHALL tie lane_cfg_err_o to 0 and include no checking logic.

Verification
REQ-033 x4, lanes=1111, beat {A0,B1,C2,D3}, ready_i=1 -> outputs A0,B1,C2,D3 on cycles 1-4 after capture, then valid=0.
REQ-034 x2, lanes=0011, back-to-back beats {11,22},{33,44}, ready_i=1 -> 11,22,33,44 on 4 consecutive cycles, with striped_data_ready_o=1 on the last-symbol cycle.
REQ-035 x4, ready_i=0 for 3 cycles at cnt=1 -> output holds symbol 1 stable; sequence resumes unchanged.
REQ-036 lanes=0000, striped_data_valid_i=1 -> striped_data_ready_o=0, destriped_data_valid_o stays 0.
REQ-037 rst_ni low after 2 of 4 symbols -> outputs 0 immediately; after release, IDLE, no residual symbols.
REQ-038 DESTRIPER_LANE_CHECK_EN defined, lanes=0101 with valid=1 -> lane_cfg_err_o=1 next cycle and stays 1 until reset; symbols from lanes 0,1 emitted.
